buzzer_alert_sequencer: RTL
===========================

# buzzer_alert_sequencer

Arbitrates four alert requesters onto the single active-low buzzer and plays a distinct beep pattern per requester. Requester *i* sounds *i*+1 beeps; fixed priority, no preemption. Sits between the game/status logic, which raises alert requests, and the buzzer pin. It replaces direct one-shot triggering of the buzzer.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz; must be a multiple of 1000.
- `BEEP_MS`, 200: length of each beep (buzzer low), in ms; must be ≥1.
- `GAP_MS`, 150: silence between beeps and after the last beep of a sequence, in ms; must be ≥1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `req`  in  4  alert requests; a rising edge on each bit is an event.
- `mute`  in  1  when 1, forces the buzzer silent; sequencing timing is unaffected.
- `buzzer_out`  out  1  buzzer drive, active-low; 0 means sounding.
- `busy`  out  1  1 while a sequence is in progress (any state other than IDLE).
- `grant`  out  2  index of the requester currently being served; valid while `busy`=1.
- `done`  out  1  one-cycle pulse when a sequence's final gap ends.

## Operation
- Edge detect: `req_prev` is registered every cycle. At each edge where `req[i]`=1 and `req_prev[i]`=0, set `pending[i]`.
- A bit in `pending` clears only when the FSM grants that requester. An edge on the requester currently being served re-sets its bit, so the requester is served again later.
- FSM states: IDLE, BEEP, GAP.
  - **IDLE:** if `pending`≠0, select the lowest set index. Load `grant`, set `beeps_left` = index+1, clear that pending bit, zero `cnt`, go to BEEP.
  - **BEEP:** `cnt` counts up to `BEEP_CYC`-1, where `BEEP_CYC` = `BEEP_MS`·(`CLK_FREQ`/1000). At the limit, decrement `beeps_left`, zero `cnt`, go to GAP.
  - **GAP:** `cnt` counts up to `GAP_CYC`-1. At the limit:
    - If `beeps_left`≠0, go to BEEP.
    - Otherwise pulse `done` and go to IDLE.
- The next grant is taken from IDLE on the cycle after `done`. There is no idle gap beyond one cycle.
- Pending bits set in the same cycle as the IDLE decision are visible in the next IDLE evaluation.
- `buzzer_out` = 0 iff state = BEEP and `mute` = 0. It is registered, so it changes on the clock edge that enters or leaves BEEP.
- `mute` is sampled every cycle. Asserting it mid-beep silences the buzzer on the next edge. The sequence continues and `done` still fires.
- `cnt` is 32 bits unsigned. Parameter legality (`BEEP_CYC`, `GAP_CYC` < 2^32) is checked at elaboration.
- Simultaneous edges on several `req` bits: all are latched and served in ascending index order.
- Reset mid-sequence: everything returns immediately to reset values and all pending requests are lost.

## Timing
Reset values:
- State IDLE.
- `pending`=0, `req_prev`=0, `cnt`=0, `beeps_left`=0.
- `buzzer_out`=1, `busy`=0, `grant`=0, `done`=0.

Request-to-sound latency:
- A rising edge of `req[i]` sampled at clock edge *n* sets `pending` at *n*.
- The FSM enters BEEP at *n*+1, so `buzzer_out`=0 and `busy`=1 after edge *n*+1.

Durations:
- Each beep holds `buzzer_out` low for exactly `BEEP_CYC` cycles.
- Each gap lasts exactly `GAP_CYC` cycles.
- A sequence for requester *i* occupies (*i*+1)·(`BEEP_CYC`+`GAP_CYC`) cycles. `done` is high during the last cycle of the final gap.

## Structure
- Shared include `buzzer_defs.vh` holds:
  - the state encodings `ST_IDLE`, `ST_BEEP`, `ST_GAP`;
  - the requester count constant `N_REQ`=4;
  - the active-low level constants `BUZZ_ON`=0 and `BUZZ_OFF`=1, reused by other buzzer blocks.
- One sub-module, `buzzer_req_latch`, holds the edge detect, the pending register, the priority select, and the clear-on-grant input. It outputs `any_pending` and `sel_idx`.

## Test plan
All scenarios use `CLK_FREQ`=10_000, `BEEP_MS`=2, `GAP_MS`=1, giving `BEEP_CYC`=20 and `GAP_CYC`=10.
- Reset: hold reset low, toggle `req` → `buzzer_out`=1, `busy`=0, `done`=0 throughout; after release, no sound without a new edge.
- Single request: pulse `req[2]` → `buzzer_out` low 1 cycle after the latch; three 20-cycle lows separated by 10-cycle highs; `done` at cycle 90 of the sequence; `grant`=2.
- Simultaneous: rising edges on `req[3]` and `req[0]` in the same cycle → one beep with `grant`=0, `done`, then next cycle four beeps with `grant`=3.
- Priority without preemption: `req[0]` edge during the `req[3]` sequence → the `req[3]` sequence completes all four beeps, then `grant`=0 for one beep.
- Mute: assert `mute` at cycle 5 of the first beep for `req[1]` → `buzzer_out` returns to 1 next edge and stays 1; `done` still occurs at cycle 60.
- Reset mid-sequence plus re-request: pull reset during a beep → `buzzer_out`=1 immediately (asynchronous). Also, a `req[1]` edge during its own sequence → the pattern replays once after `done`.

Source files
------------

// File: rtl/buzzer_alert_sequencer_pkg.sv
// buzzer_alert_sequencer_pkg: shared buzzer definitions.
// Holds the FSM state encodings, the requester count and the active-low
// buzzer drive levels reused by other buzzer blocks, plus a ms-to-cycles helper.
package buzzer_alert_sequencer_pkg;
    localparam int   N_REQ    = 4;
    localparam int   IDX_W    = $clog2(N_REQ);
    localparam int   BEEPS_W  = $clog2(N_REQ + 1);
    localparam logic BUZZ_ON  = 1'b0;
    localparam logic BUZZ_OFF = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEEP = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic longint ms_to_cyc(input longint clk_freq, input longint ms);
        return ms * (clk_freq / 1000);
    endfunction
endpackage

// File: rtl/buzzer_req_latch.sv
// buzzer_req_latch: rising-edge capture of alert requests with lowest-index select.
// Ports: clk, reset (async, active-low), req (raw requests), clr/clr_idx (drop the
// pending bit of the requester just granted), any_pending, sel_idx (lowest pending).
module buzzer_req_latch
    import buzzer_alert_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             clr,
    input  logic [IDX_W-1:0] clr_idx,
    output logic             any_pending,
    output logic [IDX_W-1:0] sel_idx
);
    logic [N_REQ-1:0] req_prev;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] clr_mask;

    assign clr_mask = clr ? ({{(N_REQ-1){1'b0}}, 1'b1} << clr_idx) : '0;

    // A fresh edge is ORed in after the clear, so an edge on the requester being
    // granted in this very cycle is kept and served again later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_prev <= '0;
            pending  <= '0;
        end else begin
            req_prev <= req;
            pending  <= (pending & ~clr_mask) | (req & ~req_prev);
        end
    end

    // Descending scan so the lowest set index is the one that sticks.
    always_comb begin
        sel_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (pending[i]) sel_idx = IDX_W'(i);
    end

    assign any_pending = |pending;
endmodule

// File: rtl/buzzer_alert_sequencer.sv
// buzzer_alert_sequencer: arbitrates alert requesters onto one active-low buzzer;
// requester i plays i+1 beeps, fixed priority, no preemption.
// Ports: clk, reset (async, active-low), req (rising edge = alert event),
// mute (silences buzzer, timing unchanged), buzzer_out (0 = sounding),
// busy (sequence in progress), grant (requester served), done (last gap cycle).
module buzzer_alert_sequencer
    import buzzer_alert_sequencer_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BEEP_MS  = 200,
    parameter int GAP_MS   = 150
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             mute,
    output logic             buzzer_out,
    output logic             busy,
    output logic [IDX_W-1:0] grant,
    output logic             done
);
    localparam longint BEEP_CYC = ms_to_cyc(CLK_FREQ, BEEP_MS);
    localparam longint GAP_CYC  = ms_to_cyc(CLK_FREQ, GAP_MS);
    localparam longint CYC_LIM  = 64'h1_0000_0000;
    localparam logic [31:0] BEEP_LAST = 32'(BEEP_CYC - 1);
    localparam logic [31:0] GAP_LAST  = 32'(GAP_CYC - 1);

    if (CLK_FREQ < 1000 || CLK_FREQ % 1000 != 0 || BEEP_MS < 1 || GAP_MS < 1 ||
        BEEP_CYC >= CYC_LIM || GAP_CYC >= CYC_LIM) begin : g_bad_params
        $error("buzzer_alert_sequencer: illegal CLK_FREQ/BEEP_MS/GAP_MS");
    end

    state_t             state, state_n;
    logic [31:0]        cnt, cnt_n;
    logic [BEEPS_W-1:0] beeps_left, beeps_n;
    logic [IDX_W-1:0]   grant_n;
    logic               clr;
    logic               any_pending;
    logic [IDX_W-1:0]   sel_idx;

    buzzer_req_latch u_req_latch (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .clr         (clr),
        .clr_idx     (sel_idx),
        .any_pending (any_pending),
        .sel_idx     (sel_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            beeps_left <= '0;
            grant      <= '0;
            buzzer_out <= BUZZ_OFF;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            beeps_left <= beeps_n;
            grant      <= grant_n;
            buzzer_out <= (state_n == ST_BEEP && !mute) ? BUZZ_ON : BUZZ_OFF;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        beeps_n = beeps_left;
        grant_n = grant;
        clr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_pending) begin
                    grant_n = sel_idx;
                    beeps_n = BEEPS_W'(sel_idx) + BEEPS_W'(1);
                    clr     = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_BEEP;
                end
            end
            ST_BEEP: begin
                if (cnt == BEEP_LAST) begin
                    beeps_n = beeps_left - BEEPS_W'(1);
                    cnt_n   = '0;
                    state_n = ST_GAP;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = (beeps_left != '0) ? ST_BEEP : ST_IDLE;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_GAP) && (cnt == GAP_LAST) && (beeps_left == '0);
endmodule
